// File: rtl/fport_pkg.sv
// Shared constants, state encoding and the byte-stuffing predicate for the
// FPort telemetry path.
package fport_pkg;

    localparam logic [7:0] FPORT_FRAME_DELIM  = 8'h7E;
    localparam logic [7:0] FPORT_ESC          = 8'h7D;
    localparam logic [7:0] FPORT_ESC_XOR      = 8'h20;
    localparam logic [7:0] FPORT_DOWNLINK_LEN = 8'h08;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_BODY  = 3'd2;
    localparam logic [2:0] ST_ESC   = 3'd3;
    localparam logic [2:0] ST_CRC   = 3'd4;
    localparam logic [2:0] ST_END   = 3'd5;

    function automatic logic needs_stuff(input logic [7:0] b);
        return (b == FPORT_FRAME_DELIM) || (b == FPORT_ESC);
    endfunction

endpackage

// File: rtl/fport_crc8.sv
// FPort checksum: 8-bit end-around-carry sum, reported as 0xFF minus the sum.
module fport_crc8 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] byte_in,
    output logic [7:0] crc_out
);

    logic [7:0] acc_reg;
    logic [8:0] sum_next;

    assign sum_next = {1'b0, acc_reg} + {1'b0, byte_in};
    assign crc_out  = 8'hFF - acc_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_reg <= 8'h00;
        end else if (clear) begin
            acc_reg <= 8'h00;
        end else if (add) begin
            acc_reg <= sum_next[7:0] + {7'd0, sum_next[8]};
        end
    end

endmodule

// File: rtl/fport_telemetry_tx.sv
// FPort downlink telemetry framer: serialises one sensor frame, with byte
// stuffing and checksum, onto a valid/ready byte stream.
module fport_telemetry_tx
    import fport_pkg::*;
#(
    parameter logic [7:0] DOWNLINK_TYPE = 8'h81,
    parameter logic [7:0] PRIM_DATA     = 8'h10
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        send,
    input  logic [15:0] app_id,
    input  logic [31:0] value,
    output logic        busy,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [2:0]  state_reg;
    logic [3:0]  idx_reg;
    logic [15:0] app_id_reg;
    logic [31:0] value_reg;
    logic [7:0]  raw_byte;
    logic [7:0]  crc_value;
    logic        xfer;

    assign tx_valid = (state_reg != ST_IDLE);
    assign busy     = (state_reg != ST_IDLE);
    assign xfer     = tx_valid && tx_ready;
    assign done     = (state_reg == ST_END) && tx_ready;

    // idx 0..8 walks the checksummed body, idx 9 selects the checksum itself.
    always_comb begin
        raw_byte = 8'h00;
        case (idx_reg)
            4'd0:    raw_byte = FPORT_DOWNLINK_LEN;
            4'd1:    raw_byte = DOWNLINK_TYPE;
            4'd2:    raw_byte = PRIM_DATA;
            4'd3:    raw_byte = app_id_reg[7:0];
            4'd4:    raw_byte = app_id_reg[15:8];
            4'd5:    raw_byte = value_reg[7:0];
            4'd6:    raw_byte = value_reg[15:8];
            4'd7:    raw_byte = value_reg[23:16];
            4'd8:    raw_byte = value_reg[31:24];
            4'd9:    raw_byte = crc_value;
            default: raw_byte = 8'h00;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        case (state_reg)
            ST_START, ST_END: tx_data = FPORT_FRAME_DELIM;
            ST_BODY, ST_CRC:  tx_data = needs_stuff(raw_byte) ? FPORT_ESC : raw_byte;
            ST_ESC:           tx_data = raw_byte ^ FPORT_ESC_XOR;
            default:          tx_data = 8'h00;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            idx_reg    <= 4'd0;
            app_id_reg <= 16'h0000;
            value_reg  <= 32'h0000_0000;
        end else begin
            case (state_reg)
                ST_IDLE: if (send) begin
                    state_reg  <= ST_START;
                    idx_reg    <= 4'd0;
                    app_id_reg <= app_id;
                    value_reg  <= value;
                end
                ST_START: if (xfer) state_reg <= ST_BODY;
                ST_BODY: if (xfer) begin
                    if (needs_stuff(raw_byte)) begin
                        state_reg <= ST_ESC;
                    end else if (idx_reg == 4'd8) begin
                        state_reg <= ST_CRC;
                        idx_reg   <= 4'd9;
                    end else begin
                        idx_reg <= idx_reg + 4'd1;
                    end
                end
                // The escaped second half returns to wherever the plain byte would have gone.
                ST_ESC: if (xfer) begin
                    if (idx_reg == 4'd9) begin
                        state_reg <= ST_END;
                    end else if (idx_reg == 4'd8) begin
                        state_reg <= ST_CRC;
                        idx_reg   <= 4'd9;
                    end else begin
                        state_reg <= ST_BODY;
                        idx_reg   <= idx_reg + 4'd1;
                    end
                end
                ST_CRC: if (xfer) state_reg <= needs_stuff(raw_byte) ? ST_ESC : ST_END;
                ST_END: if (xfer) state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Body bytes are summed once, unstuffed, on the cycle their first half transfers.
    fport_crc8 u_crc (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   ((state_reg == ST_IDLE) && send),
        .add     ((state_reg == ST_BODY) && xfer),
        .byte_in (raw_byte),
        .crc_out (crc_value)
    );

endmodule

// File: tb/tb_fport_telemetry_tx.sv
// Directed bench for fport_telemetry_tx: fixed frames, back-pressure, ignored
// sends and a mid-frame reset, each checked against hand-computed bytes.
module tb_fport_telemetry_tx;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        send;
    logic [15:0] app_id;
    logic [31:0] value;
    logic        busy;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] got [0:31];
    logic [7:0] exp_b [0:31];
    int n_got, exp_n, cycles, done_at;
    bit done_seen;

    always #5 clock = ~clock;

    fport_telemetry_tx dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .send     (send),
        .app_id   (app_id),
        .value    (value),
        .busy     (busy),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic load_exp(input logic [8*22-1:0] bytes, input int len);
        exp_n = len;
        for (int i = 0; i < len; i++) exp_b[i] = bytes[(len-1-i)*8 +: 8];
    endtask

    // Sends one frame and records every transferred byte, bounded by a cycle budget.
    task automatic run_frame(input logic [15:0] a, input logic [31:0] v,
                             input bit rnd, input bit inject, input string tag);
        bit pv, pr;
        logic [7:0] pd;
        n_got = 0; cycles = 0; done_at = -1; done_seen = 0;
        pv = 0; pr = 0; pd = 8'h00;
        @(negedge clock);
        send = 1'b1; app_id = a; value = v; tx_ready = 1'b0;
        @(negedge clock);
        send = 1'b0;
        #1;
        check({tag, ".first_valid"}, {31'd0, tx_valid}, 32'd1);
        check({tag, ".busy"}, {31'd0, busy}, 32'd1);
        for (int c = 0; c < 300 && !done_seen; c++) begin
            if (c > 0) @(negedge clock);
            if (inject) begin
                send   = (c == 3);
                app_id = 16'hBEEF;
                value  = 32'hDEAD_BEEF;
            end
            tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pv && !pr) begin
                check({tag, ".hold_valid"}, {31'd0, tx_valid}, 32'd1);
                check({tag, ".hold_data"}, {24'd0, tx_data}, {24'd0, pd});
            end
            if (tx_valid && tx_ready && n_got < 32) begin
                got[n_got] = tx_data;
                n_got++;
            end
            if (done) begin
                done_seen = 1;
                done_at   = n_got - 1;
                cycles    = c + 1;
            end
            pv = tx_valid; pr = tx_ready; pd = tx_data;
        end
        send = 1'b0;
        check({tag, ".done_seen"}, {31'd0, done_seen}, 32'd1);
        @(negedge clock);
        #1;
        check({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".idle_valid"}, {31'd0, tx_valid}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input bit timed);
        check({tag, ".len"}, n_got, exp_n);
        for (int i = 0; i < exp_n; i++)
            check($sformatf("%s.byte%0d", tag, i), {24'd0, (i < n_got) ? got[i] : 8'hxx},
                  {24'd0, exp_b[i]});
        check({tag, ".done_at"}, done_at, exp_n - 1);
        if (timed) check({tag, ".cycles"}, cycles, exp_n);
    endtask

    initial begin
        reset_n = 1'b0; send = 1'b0; app_id = 16'h0; value = 32'h0; tx_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.valid", {31'd0, tx_valid}, 32'd0);
        check("reset.data", {24'd0, tx_data}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;

        // Test 1: plain frame, no stuffing
        load_exp(96'h7E_08_81_10_10_02_64_00_00_00_EF_7E, 12);
        run_frame(16'h0210, 32'h0000_0064, 1'b0, 1'b0, "t1");
        check_frame("t1", 1'b1);

        // Test 2: value byte needs stuffing
        load_exp(104'h7E_08_81_10_10_02_7D_5E_00_00_00_D5_7E, 13);
        run_frame(16'h0210, 32'h0000_007E, 1'b0, 1'b0, "t2");
        check_frame("t2", 1'b1);

        // Test 3: checksum itself is 0x7E and gets stuffed
        load_exp(104'h7E_08_81_10_10_02_D5_00_00_00_7D_5E_7E, 13);
        run_frame(16'h0210, 32'h0000_00D5, 1'b0, 1'b0, "t3");
        check_frame("t3", 1'b1);

        // Test 4: random back-pressure plus a send while busy
        load_exp(96'h7E_08_81_10_10_02_64_00_00_00_EF_7E, 12);
        run_frame(16'h0210, 32'h0000_0064, 1'b1, 1'b1, "t4");
        check_frame("t4", 1'b0);

        // Test 5: reset during value[15:8], with a coincident send
        @(negedge clock);
        send = 1'b1; app_id = 16'h0210; value = 32'h0000_A564;
        @(negedge clock);
        send = 1'b0; tx_ready = 1'b1;
        repeat (7) @(negedge clock);
        #1;
        check("t5.pre_reset_data", {24'd0, tx_data}, 32'h0000_00A5);
        reset_n = 1'b0; send = 1'b1;
        @(negedge clock);
        reset_n = 1'b1; send = 1'b0; tx_ready = 1'b0;
        #1;
        check("t5.valid", {31'd0, tx_valid}, 32'd0);
        check("t5.busy", {31'd0, busy}, 32'd0);
        check("t5.data", {24'd0, tx_data}, 32'd0);
        check("t5.done", {31'd0, done}, 32'd0);
        load_exp(96'h7E_08_81_10_10_02_64_00_00_00_EF_7E, 12);
        run_frame(16'h0210, 32'h0000_0064, 1'b0, 1'b0, "t5r");
        check_frame("t5r", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fport_telemetry_tx.md
FPORT_TELEMETRY_TX -- requirements
Module: fport_telemetry_tx

Interface
REQ-001 The block SHALL have parameter DOWNLINK_TYPE, default 8'h81, the FPort frame type byte for downlink telemetry.
REQ-002 The block SHALL have parameter PRIM_DATA, default 8'h10, the telemetry primitive byte meaning "data frame".
REQ-003 The block SHALL have port clock, input, 1, the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, a synchronous, active-low reset.
REQ-005 The block SHALL have port send, input, 1, a one-cycle request to transmit one telemetry frame.
REQ-006 The block SHALL have port app_id, input, 16, the sensor application ID, captured on an accepted send.
REQ-007 The block SHALL have port value, input, 32, the sensor value, captured on an accepted send.
REQ-008 The block SHALL have port busy, output, 1, high from the cycle after an accepted send until done.
REQ-009 The block SHALL have port tx_data, output, 8, the byte offered to the UART byte transmitter.
REQ-010 The block SHALL have port tx_valid, output, 1, high while tx_data holds a valid byte.
REQ-011 The block SHALL have port tx_ready, input, 1, high when the UART transmitter accepts a byte.
REQ-012 The block SHALL have port done, output, 1, a one-cycle pulse when the final 0x7E byte is accepted.

Function
REQ-013 A send SHALL be accepted only in IDLE; a send while busy SHALL be ignored, with no queueing.
REQ-014 The logical frame SHALL be, in order: 0x7E, 0x08, DOWNLINK_TYPE, PRIM_DATA, app_id[7:0], app_id[15:8], value[7:0], value[15:8], value[23:16], value[31:24], CRC, 0x7E.
REQ-015 A byte SHALL transfer only on a cycle where tx_valid and tx_ready are both high.
REQ-016 Once asserted, tx_valid and tx_data SHALL stay stable until that transfer.
REQ-017 The CRC SHALL be accumulated over logical bytes 1..9 (0x08 through value[31:24]) with an 8-bit end-around-carry sum: acc = (acc + b)[7:0] + (acc + b)[8].
REQ-018 The CRC accumulator SHALL start at 0 for each frame.
REQ-019 The CRC SHALL equal 0xFF - acc.
REQ-020 Byte stuffing SHALL apply to logical bytes 1..10 (the length byte through the CRC), and never to the start or end 0x7E.
REQ-021 Any stuffed byte equal to 0x7E or 0x7D SHALL be emitted as 0x7D followed by (byte XOR 0x20).
REQ-022 The CRC SHALL always be computed on the unstuffed bytes.
REQ-023 The state machine SHALL have states IDLE, START, BODY, ESC, CRC, END.
REQ-024 The state transitions SHALL be:
- IDLE -> START on send.
- START -> BODY on transfer.
- BODY -> ESC when the current byte needs stuffing (0x7D is emitted first).
- ESC -> BODY on transfer.
- BODY -> CRC after the 9th body byte transfers.
- CRC -> ESC or END.
- END -> IDLE on transfer, pulsing done.
REQ-025 The first tx_valid SHALL assert the cycle after the accepted send.
REQ-026 With tx_ready held high, the frame SHALL complete in 12 + N cycles, where N is the number of stuffed bytes, with no idle cycles between bytes.
REQ-027 The bytes emitted per frame SHALL total between 12 and 22 inclusive.

Reset
REQ-028 While reset_n is low at a rising edge, the block SHALL force: state to IDLE, busy=0, tx_valid=0, tx_data=0x00, done=0, CRC accumulator=0.
REQ-029 A reset mid-frame SHALL abort the frame; the next send SHALL produce a complete fresh frame.
REQ-030 A send coincident with reset_n low SHALL be ignored.

Structure
REQ-031 Package fport_pkg SHALL hold FPORT_FRAME_DELIM=8'h7E, FPORT_ESC=8'h7D, FPORT_ESC_XOR=8'h20, FPORT_DOWNLINK_LEN=8'h08, and the state encoding.
REQ-032 The end-around-carry CRC accumulator SHALL be the sub-module fport_crc8, with ports clock, reset_n, clear, add, byte_in, crc_out.
REQ-033 fport_crc8 SHALL be reused by fport_rx_decoder.
REQ-034 Only the captured app_id and value registers, a byte index and the state register SHALL be held; no FIFO.

Verification
REQ-035 Test 1: app_id=0x0210, value=0x00000064, tx_ready=1 -> 7E 08 81 10 10 02 64 00 00 00 EF 7E; done on the 12th transfer.
REQ-036 Test 2: value=0x0000007E, app_id=0x0210 -> 7E 08 81 10 10 02 7D 5E 00 00 00 D5 7E (13 bytes).
REQ-037 Test 3: value=0x000000D5, app_id=0x0210 -> CRC=0x7E, emitted as 7D 5E before the final 7E.
REQ-038 Test 4: tx_ready toggled randomly -> byte stream identical to Test 1; tx_data stable while tx_valid=1 and tx_ready=0; a second send while busy is ignored.
REQ-039 Test 5: reset_n low for 1 cycle during value[15:8] -> next cycle tx_valid=0 and busy=0; the following send yields a full correct frame.
